// File: rtl/satd_pkg.sv
// Shared constants and read-side state encoding for the SATD transpose/shift buffer.
package satd_pkg;

   localparam int SATD_ROWS = 8;
   localparam int SATD_COLS = 8;
   localparam int SATD_DW   = 10;

   typedef enum logic {
      R_IDLE  = 1'b0,
      R_SHIFT = 1'b1
   } rstate_t;

endpackage

// File: rtl/satd_buffer_ctrl.sv
// Ping-pong sequencer for the SATD transpose buffer: rows are stored into one bank
// while the other bank is shifted out column by column.
module satd_buffer_ctrl
   import satd_pkg::*;
#(
   parameter int ROWS      = SATD_ROWS,
   parameter int COLS      = SATD_COLS,
   parameter int BLK_CNT_W = 8
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic                 wr_en,
   output logic                 wr_bank,
   output logic                 wr_half,
   output logic [1:0]           cycle,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 shift_en,
   output logic                 rd_bank,
   output logic [2:0]           col_idx,
   output logic                 out_first,
   output logic                 out_last,
   output logic                 blk_done,
   output logic [BLK_CNT_W-1:0] blk_cnt,
   output logic                 busy
);

   localparam logic [2:0] LAST_ROW = 3'(ROWS - 1);
   localparam logic [2:0] LAST_COL = 3'(COLS - 1);

   logic [2:0] wr_row;
   logic [1:0] bank_full;
   rstate_t    rstate;
   logic       row_last;
   logic       col_last;

   // in_ready depends only on registers, so out_ready never reaches it combinationally
   assign in_ready  = ~bank_full[wr_bank];
   assign wr_en     = in_valid & in_ready;
   assign wr_half   = wr_row[2];
   assign cycle     = wr_row[1:0];
   assign row_last  = (wr_row == LAST_ROW);

   assign out_valid = (rstate == R_SHIFT);
   assign shift_en  = out_valid & out_ready;
   assign col_last  = (col_idx == LAST_COL);
   assign out_first = out_valid & (col_idx == 3'd0);
   assign out_last  = out_valid & col_last;
   assign blk_done  = shift_en & col_last;

   assign busy      = (|bank_full) | (wr_row != 3'd0);

   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_row  <= 3'd0;
         wr_bank <= 1'b0;
      end else if (wr_en) begin
         if (row_last) begin
            wr_row  <= 3'd0;
            wr_bank <= ~wr_bank;
         end else begin
            wr_row  <= wr_row + 3'd1;
         end
      end
   end

   // Writes only target empty banks and reads only full ones, so set and clear never collide
   always_ff @(posedge CLK) begin
      if (RST) begin
         bank_full <= 2'b00;
      end else begin
         if (wr_en && row_last) bank_full[wr_bank] <= 1'b1;
         if (blk_done)          bank_full[rd_bank] <= 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         rstate  <= R_IDLE;
         rd_bank <= 1'b0;
         col_idx <= 3'd0;
         blk_cnt <= '0;
      end else begin
         case (rstate)
            R_IDLE: begin
               if (bank_full[rd_bank]) rstate <= R_SHIFT;
            end
            R_SHIFT: begin
               if (shift_en) begin
                  if (col_last) begin
                     col_idx <= 3'd0;
                     rd_bank <= ~rd_bank;
                     blk_cnt <= blk_cnt + BLK_CNT_W'(1);
                     // chain straight into the other bank when it is already loaded
                     rstate  <= bank_full[~rd_bank] ? R_SHIFT : R_IDLE;
                  end else begin
                     col_idx <= col_idx + 3'd1;
                  end
               end
            end
            default: rstate <= R_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_satd_buffer_ctrl.sv
// Scenario bench for satd_buffer_ctrl with a row/column scoreboard running alongside.
module tb_satd_buffer_ctrl;

   localparam int BLK_CNT_W = 8;

   logic                 CLK = 1'b0;
   logic                 RST;
   logic                 in_valid;
   logic                 in_ready;
   logic                 wr_en;
   logic                 wr_bank;
   logic                 wr_half;
   logic [1:0]           cycle;
   logic                 out_valid;
   logic                 out_ready;
   logic                 shift_en;
   logic                 rd_bank;
   logic [2:0]           col_idx;
   logic                 out_first;
   logic                 out_last;
   logic                 blk_done;
   logic [BLK_CNT_W-1:0] blk_cnt;
   logic                 busy;

   int passed = 0;
   int total  = 0;

   satd_buffer_ctrl #(.BLK_CNT_W(BLK_CNT_W)) dut (
      .CLK(CLK), .RST(RST),
      .in_valid(in_valid), .in_ready(in_ready),
      .wr_en(wr_en), .wr_bank(wr_bank), .wr_half(wr_half), .cycle(cycle),
      .out_valid(out_valid), .out_ready(out_ready), .shift_en(shift_en),
      .rd_bank(rd_bank), .col_idx(col_idx),
      .out_first(out_first), .out_last(out_last),
      .blk_done(blk_done), .blk_cnt(blk_cnt), .busy(busy)
   );

   always #5 CLK = ~CLK;

   // Scoreboard: each completed block of accepted rows queues its 8 expected columns
   logic [3:0]           sb[$];
   int                   rows_acc = 0;
   logic [BLK_CNT_W-1:0] exp_blk = '0;

   always @(negedge CLK) begin
      logic [3:0] e;
      logic       eb;
      if (RST === 1'b1) begin
         rows_acc = 0;
         sb.delete();
         exp_blk = '0;
      end else begin
         total++;
         if (wr_en !== (in_valid & in_ready))
            $display("FAIL wr_en_strobe: got %b want %b", wr_en, in_valid & in_ready);
         else passed++;
         total++;
         if (shift_en !== (out_valid & out_ready))
            $display("FAIL shift_en_strobe: got %b want %b", shift_en, out_valid & out_ready);
         else passed++;
         if (in_valid && in_ready) begin
            eb = 1'((rows_acc / 8) % 2);
            total++;
            if ({wr_bank, wr_half, cycle} !== {eb, 1'((rows_acc % 8) / 4), 2'(rows_acc % 4)})
               $display("FAIL store_ctrl row %0d: got bank=%b half=%b cycle=%0d want bank=%b half=%0d cycle=%0d",
                        rows_acc, wr_bank, wr_half, cycle, eb, (rows_acc % 8) / 4, rows_acc % 4);
            else passed++;
            rows_acc++;
            if (rows_acc % 8 == 0)
               for (int c = 0; c < 8; c++) sb.push_back({eb, 3'(c)});
         end
         if (out_valid && out_ready) begin
            total++;
            if (sb.size() == 0) begin
               $display("FAIL unexpected_column: got bank=%b col=%0d want no column", rd_bank, col_idx);
            end else begin
               e = sb.pop_front();
               if ({rd_bank, col_idx} !== e)
                  $display("FAIL column_order: got bank=%b col=%0d want bank=%b col=%0d",
                           rd_bank, col_idx, e[3], e[2:0]);
               else passed++;
               total++;
               if ({out_first, out_last, blk_done} !== {e[2:0] == 3'd0, e[2:0] == 3'd7, e[2:0] == 3'd7})
                  $display("FAIL col_flags col %0d: got first=%b last=%b done=%b", e[2:0], out_first, out_last, blk_done);
               else passed++;
               total++;
               if (blk_cnt !== exp_blk)
                  $display("FAIL blk_cnt_track: got %0d want %0d", blk_cnt, exp_blk);
               else passed++;
               if (e[2:0] == 3'd7) exp_blk = exp_blk + 1'b1;
            end
         end else begin
            total++;
            if (blk_done !== 1'b0) $display("FAIL blk_done_idle: got %b want 0", blk_done);
            else passed++;
         end
      end
   end

   task automatic do_reset();
      RST = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge CLK);
      #1 RST = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge CLK);
      total++;
      if ({in_ready, out_valid, busy, wr_en, shift_en, blk_done} !== 6'b100000)
         $display("FAIL reset_outputs: got rdy=%b ov=%b busy=%b we=%b se=%b done=%b want 1 0 0 0 0 0",
                  in_ready, out_valid, busy, wr_en, shift_en, blk_done);
      else passed++;
      total++;
      if (blk_cnt !== '0 || rd_bank !== 1'b0 || col_idx !== 3'd0)
         $display("FAIL reset_regs: got cnt=%0d rd=%b col=%0d want 0 0 0", blk_cnt, rd_bank, col_idx);
      else passed++;
      @(posedge CLK); #1;
   endtask

   task automatic test_single_block(input bit do_rst);
      int first_ov = -1;
      int done_c   = -1;
      if (do_rst) do_reset();
      out_ready = 1'b1;
      for (int c = 0; c < 30; c++) begin
         in_valid = (c < 8);
         @(negedge CLK);
         if (out_valid === 1'b1 && first_ov < 0) first_ov = c;
         if (blk_done === 1'b1) done_c = c;
         @(posedge CLK); #1;
      end
      in_valid = 1'b0;
      total++;
      if (first_ov != 9) $display("FAIL single_first_valid: got %0d want 9", first_ov);
      else passed++;
      total++;
      if (done_c != 16) $display("FAIL single_blk_done: got %0d want 16", done_c);
      else passed++;
      total++;
      if (blk_cnt !== 8'd1) $display("FAIL single_blk_cnt: got %0d want 1", blk_cnt);
      else passed++;
   endtask

   task automatic test_back_to_back();
      int acc = 0;
      int stalls = 0;
      int ov_cnt = 0;
      int done_c[$];
      logic rdb[$];
      do_reset();
      out_ready = 1'b1;
      for (int c = 0; c < 60; c++) begin
         in_valid = (acc < 24);
         @(negedge CLK);
         if (in_valid && in_ready) acc++;
         else if (in_valid) stalls++;
         if (out_valid === 1'b1 && c >= 9 && c <= 24) ov_cnt++;
         if (blk_done === 1'b1) begin
            done_c.push_back(c);
            rdb.push_back(rd_bank);
         end
         @(posedge CLK); #1;
      end
      in_valid = 1'b0;
      total++;
      if (acc != 24) $display("FAIL b2b_accepted: got %0d want 24", acc);
      else passed++;
      // the bank being drained is still full on the cycle its last column leaves
      total++;
      if (stalls != 1) $display("FAIL b2b_stalls: got %0d want 1", stalls);
      else passed++;
      total++;
      if (ov_cnt != 16) $display("FAIL b2b_continuous_out: got %0d want 16", ov_cnt);
      else passed++;
      total++;
      if (done_c.size() != 3) begin
         $display("FAIL b2b_done_count: got %0d want 3", done_c.size());
      end else if (done_c[0] != 16 || done_c[1] != 24 || done_c[2] != 33 ||
                   rdb[0] !== 1'b0 || rdb[1] !== 1'b1 || rdb[2] !== 1'b0) begin
         $display("FAIL b2b_done_seq: got %0d/%b %0d/%b %0d/%b want 16/0 24/1 33/0",
                  done_c[0], rdb[0], done_c[1], rdb[1], done_c[2], rdb[2]);
      end else passed++;
      total++;
      if (blk_cnt !== 8'd3 || sb.size() != 0)
         $display("FAIL b2b_blk_cnt: got %0d pending=%0d want 3 pending=0", blk_cnt, sb.size());
      else passed++;
   endtask

   task automatic test_stall_downstream();
      int acc = 0;
      int shifts = 0;
      bit seen = 0;
      do_reset();
      out_ready = 1'b0;
      for (int c = 0; c < 24; c++) begin
         in_valid = 1'b1;
         @(negedge CLK);
         if (in_valid && in_ready) acc++;
         @(posedge CLK); #1;
      end
      in_valid = 1'b0;
      @(negedge CLK);
      total++;
      if (acc != 16) $display("FAIL stall_accepted: got %0d want 16", acc);
      else passed++;
      total++;
      if ({in_ready, out_valid, busy} !== 3'b011 || dut.bank_full !== 2'b11)
         $display("FAIL stall_full: got rdy=%b ov=%b busy=%b full=%b want 0 1 1 11",
                  in_ready, out_valid, busy, dut.bank_full);
      else passed++;
      @(posedge CLK); #1;
      out_ready = 1'b1;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge CLK);
         if (shift_en === 1'b1) shifts++;
         if (blk_done === 1'b1) begin
            seen = 1;
            total++;
            if (in_ready !== 1'b0 || shifts != 8)
               $display("FAIL stall_drain: got rdy=%b shifts=%0d want 0 8", in_ready, shifts);
            else passed++;
         end
         @(posedge CLK); #1;
      end
      if (!seen) begin
         total++;
         $display("FAIL stall_drain_timeout: got no blk_done want one within 20 cycles");
      end
      @(negedge CLK);
      total++;
      if (in_ready !== 1'b1) $display("FAIL stall_reopen: got in_ready=%b want 1", in_ready);
      else passed++;
      @(posedge CLK); #1;
      repeat (12) @(posedge CLK);
      #1;
      total++;
      if (blk_cnt !== 8'd2 || sb.size() != 0)
         $display("FAIL stall_final_cnt: got %0d pending=%0d want 2 pending=0", blk_cnt, sb.size());
      else passed++;
   endtask

   task automatic test_upstream_gaps();
      int acc = 0;
      int a8 = -1;
      int first_ov = -1;
      int row_bad = 0;
      do_reset();
      out_ready = 1'b1;
      for (int c = 0; c < 40; c++) begin
         in_valid = (acc < 8) && (c % 2 == 0);
         @(negedge CLK);
         if (dut.wr_row !== 3'(acc % 8)) row_bad++;
         if (in_valid && in_ready) begin
            acc++;
            if (acc == 8) a8 = c;
         end
         if (out_valid === 1'b1 && first_ov < 0) first_ov = c;
         @(posedge CLK); #1;
      end
      in_valid = 1'b0;
      total++;
      if (row_bad != 0) $display("FAIL gaps_wr_row: got %0d bad cycles want 0", row_bad);
      else passed++;
      total++;
      if (a8 != 14 || first_ov != 16)
         $display("FAIL gaps_latency: got row8=%0d first_ov=%0d want 14 16", a8, first_ov);
      else passed++;
   endtask

   task automatic test_reset_mid_block();
      int dones = 0;
      do_reset();
      out_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         in_valid = 1'b1;
         @(posedge CLK); #1;
      end
      in_valid = 1'b0;
      RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
      @(negedge CLK);
      total++;
      if ({in_ready, out_valid, busy} !== 3'b100 || dut.wr_row !== 3'd0)
         $display("FAIL midrst_state: got rdy=%b ov=%b busy=%b row=%0d want 1 0 0 0",
                  in_ready, out_valid, busy, dut.wr_row);
      else passed++;
      @(posedge CLK); #1;
      for (int c = 0; c < 15; c++) begin
         @(negedge CLK);
         if (blk_done === 1'b1 || out_valid === 1'b1) dones++;
         @(posedge CLK); #1;
      end
      total++;
      if (dones != 0 || blk_cnt !== '0)
         $display("FAIL midrst_no_done: got %0d events cnt=%0d want 0 0", dones, blk_cnt);
      else passed++;
      test_single_block(1'b0);
   endtask

   task automatic test_stall_mid_shift();
      int bad = 0;
      int done_c = -1;
      do_reset();
      for (int c = 0; c < 30; c++) begin
         in_valid  = (c < 8);
         out_ready = !(c >= 12 && c < 16);
         @(negedge CLK);
         if (c >= 12 && c < 16 && (col_idx !== 3'd3 || out_valid !== 1'b1 || shift_en !== 1'b0)) bad++;
         if (blk_done === 1'b1) done_c = c;
         @(posedge CLK); #1;
      end
      in_valid = 1'b0;
      total++;
      if (bad != 0) $display("FAIL midshift_hold: got %0d bad cycles want 0", bad);
      else passed++;
      total++;
      if (done_c != 20 || blk_cnt !== 8'd1)
         $display("FAIL midshift_done: got cycle=%0d cnt=%0d want 20 1", done_c, blk_cnt);
      else passed++;
   endtask

   initial begin
      RST = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      test_reset();
      test_single_block(1'b1);
      test_back_to_back();
      test_stall_downstream();
      test_upstream_gaps();
      test_reset_mid_block();
      test_stall_mid_shift();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
